// File: rtl/edu_tpu_mm_if.sv
// Wishbone slave bundle for the edu_tpu_mm register window.
interface edu_tpu_mm_if;
  logic        caravel_wb_stb_i;
  logic        caravel_wb_cyc_i;
  logic        caravel_wb_we_i;
  logic [3:0]  caravel_wb_sel_i;
  logic [31:0] caravel_wb_dat_i;
  logic [31:0] caravel_wb_adr_i;
  logic        caravel_wb_ack_o;
  logic [31:0] caravel_wb_dat_o;

  // A request is valid while cyc & stb are high and is complete on the single-cycle ack;
  // the master holds the request stable until it sees ack, then drops stb.
  modport master (
    output caravel_wb_stb_i, caravel_wb_cyc_i, caravel_wb_we_i,
           caravel_wb_sel_i, caravel_wb_dat_i, caravel_wb_adr_i,
    input  caravel_wb_ack_o, caravel_wb_dat_o
  );

  modport slave (
    input  caravel_wb_stb_i, caravel_wb_cyc_i, caravel_wb_we_i,
           caravel_wb_sel_i, caravel_wb_dat_i, caravel_wb_adr_i,
    output caravel_wb_ack_o, caravel_wb_dat_o
  );
endinterface

// File: rtl/edu_tpu_mm.sv
// Wishbone-attached N x N output-stationary systolic matrix multiplier (C = A x W)
// with memory-mapped operands, results, control and status.
module edu_tpu_mm #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          N            = 3,
  parameter int          DW           = 8,
  parameter int          ACCW         = 20
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_i,
  edu_tpu_mm_if.slave wb,
  output logic        done_irq_o,
  output logic [2:0]  dbg_state_o
);
  localparam int NN = N * N;
  localparam int TW = 5;
  localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_next;
  logic [TW-1:0]   r_t;
  logic [DW-1:0]   r_w [NN];
  logic [DW-1:0]   r_a [NN];
  logic [DW-1:0]   r_pa [NN];
  logic [DW-1:0]   r_pb [NN];
  logic [ACCW-1:0] r_acc [NN];
  logic [ACCW-1:0] r_c [NN];
  logic            r_signed, r_c_signed, r_done, r_err, r_ack;
  logic [31:0]     r_dat;

  logic            w_busy, w_hit, w_ack_next, w_aligned, w_wr, w_idx_ok;
  logic            w_ctrl_wr, w_start_req, w_clear_req, w_op_wr;
  logic [1:0]      w_region;
  logic [5:0]      w_idx;
  logic [31:0]     w_rdata, w_status;
  logic [DW-1:0]   w_a_in [N];
  logic [DW-1:0]   w_b_in [N];
  logic [DW-1:0]   w_pa_in [NN];
  logic [DW-1:0]   w_pb_in [NN];
  logic [ACCW-1:0] w_mac [NN];

  function automatic logic [ACCW-1:0] ext_op(input logic [DW-1:0] v, input logic s);
    ext_op = s ? ACCW'($signed(v)) : ACCW'(v);
  endfunction

  assign w_hit      = wb.caravel_wb_cyc_i & wb.caravel_wb_stb_i &
                      (wb.caravel_wb_adr_i[31:10] == BASE_ADDRESS[31:10]);
  assign w_ack_next = w_hit & ~r_ack;
  assign w_region   = wb.caravel_wb_adr_i[9:8];
  assign w_idx      = wb.caravel_wb_adr_i[7:2];
  assign w_aligned  = (wb.caravel_wb_adr_i[1:0] == 2'b00);
  assign w_idx_ok   = (int'({26'd0, w_idx}) < NN);
  assign w_wr       = w_ack_next & wb.caravel_wb_we_i & wb.caravel_wb_sel_i[0] & w_aligned;
  assign w_ctrl_wr  = w_wr & (w_region == 2'd0) & (w_idx == 6'd0);
  assign w_start_req = w_ctrl_wr & wb.caravel_wb_dat_i[0] & ~wb.caravel_wb_dat_i[1];
  assign w_clear_req = w_ctrl_wr & wb.caravel_wb_dat_i[1];
  assign w_op_wr    = w_wr & w_idx_ok & ((w_region == 2'd1) | (w_region == 2'd2));
  assign w_status   = {20'd0, 4'(N), 5'd0, r_err, r_done, w_busy};

  assign wb.caravel_wb_ack_o = r_ack;
  assign wb.caravel_wb_dat_o = r_dat;
  assign done_irq_o          = r_done;
  assign dbg_state_o         = r_state;

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start_req) w_state_next = S_CLR;
      S_CLR: begin
        w_busy       = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_t == T_LAST) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy       = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = w_start_req ? S_CLR : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Row i sees A[i][k] and column j sees W[k][j] at step k+i / k+j, which skews
  // the operands so that matching pairs meet in PE(i,j) at step k+i+j.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a_in[i] = '0;
      w_b_in[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (r_t == TW'(i + k)) begin
          w_a_in[i] = r_a[i*N + k];
          w_b_in[i] = r_w[k*N + i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam int P = gi * N + gj;
      if (gj == 0) begin : g_left
        assign w_pa_in[P] = w_a_in[gi];
      end else begin : g_inner_a
        assign w_pa_in[P] = r_pa[P-1];
      end
      if (gi == 0) begin : g_top
        assign w_pb_in[P] = w_b_in[gj];
      end else begin : g_inner_b
        assign w_pb_in[P] = r_pb[P-N];
      end
      assign w_mac[P] = r_acc[P] + ext_op(w_pa_in[P], r_signed) * ext_op(w_pb_in[P], r_signed);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_aligned) begin
      case (w_region)
        2'd0: if (w_idx == 6'd1) w_rdata = w_status;
        2'd1: for (int e = 0; e < NN; e++) if (w_idx == 6'(e)) w_rdata = 32'(r_w[e]);
        2'd2: for (int e = 0; e < NN; e++) if (w_idx == 6'(e)) w_rdata = 32'(r_a[e]);
        default: begin
          for (int e = 0; e < NN; e++) begin
            if (w_idx == 6'(e))
              w_rdata = r_c_signed ? 32'($signed(r_c[e])) : 32'(r_c[e]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
    if (caravel_wb_rst_i) begin
      r_state    <= S_IDLE;
      r_t        <= '0;
      r_signed   <= 1'b0;
      r_c_signed <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ack      <= 1'b0;
      r_dat      <= '0;
      for (int e = 0; e < NN; e++) begin
        r_w[e]   <= '0;
        r_a[e]   <= '0;
        r_pa[e]  <= '0;
        r_pb[e]  <= '0;
        r_acc[e] <= '0;
        r_c[e]   <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_ack_next;
      r_dat   <= (w_ack_next & ~wb.caravel_wb_we_i) ? w_rdata : 32'd0;

      if (r_state == S_CLR)      r_t <= '0;
      else if (r_state == S_RUN) r_t <= r_t + 1'b1;

      for (int e = 0; e < NN; e++) begin
        if (r_state == S_CLR) begin
          r_pa[e]  <= '0;
          r_pb[e]  <= '0;
          r_acc[e] <= '0;
        end else if (r_state == S_RUN) begin
          r_pa[e]  <= w_pa_in[e];
          r_pb[e]  <= w_pb_in[e];
          r_acc[e] <= w_mac[e];
        end
        if (r_state == S_DRAIN) r_c[e] <= r_acc[e];
        if (w_op_wr && !w_busy && w_idx == 6'(e)) begin
          if (w_region == 2'd1) r_w[e] <= wb.caravel_wb_dat_i[DW-1:0];
          else                  r_a[e] <= wb.caravel_wb_dat_i[DW-1:0];
        end
      end

      if (r_state == S_DRAIN) r_c_signed <= r_signed;
      if (w_start_req && !w_busy) r_signed <= wb.caravel_wb_dat_i[2];

      // Completion outranks a CLEAR landing on the same edge.
      if (r_state == S_DRAIN)                      r_done <= 1'b1;
      else if ((w_start_req || w_clear_req) && !w_busy) r_done <= 1'b0;

      if (w_clear_req)
        r_err <= 1'b0;
      else if (w_busy && (w_op_wr || (w_ctrl_wr && wb.caravel_wb_dat_i[0])))
        r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_edu_tpu_mm.sv
// Directed scoreboard bench for edu_tpu_mm: reads push expected data, a bus monitor pops on ack.
module tb_edu_tpu_mm;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] OFF_CTRL = 32'h000, OFF_STAT = 32'h004;
  localparam logic [31:0] OFF_W = 32'h100, OFF_A = 32'h200, OFF_C = 32'h300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done_irq;
  logic [2:0] dbg_state;

  edu_tpu_mm_if wb ();

  edu_tpu_mm #(.BASE_ADDRESS(BASE), .N(3), .DW(8), .ACCW(20)) dut (
    .caravel_wb_clk_i (clk),
    .caravel_wb_rst_i (rst),
    .wb               (wb),
    .done_irq_o       (done_irq),
    .dbg_state_o      (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  logic [7:0]  a_seq  [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
  logic [7:0]  w_id   [9] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
  logic [7:0]  a_ff   [9] = '{default: 8'hFF};
  logic [7:0]  w_two  [9] = '{default: 8'h02};
  logic [7:0]  w_mix  [9] = '{8'd1, 8'd0, 8'd2, 8'd0, 8'd1, 8'd0, 8'd3, 8'd0, 8'd1};
  logic [7:0]  a_sgn  [9] = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0]  w_one  [9] = '{default: 8'h01};
  logic [31:0] c_id   [9] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
  logic [31:0] c_sneg [9] = '{default: 32'hFFFF_FFFA};
  logic [31:0] c_upos [9] = '{default: 32'h0000_05FA};
  logic [31:0] c_mix  [9] = '{32'd10, 32'd2, 32'd5, 32'd22, 32'd5, 32'd14, 32'd34, 32'd8, 32'd23};
  logic [31:0] c_zero [9] = '{default: 32'd0};
  logic [31:0] c_sgn  [9] = '{32'hFFFF_FFF7, 32'hFFFF_FFF7, 32'hFFFF_FFF7,
                              32'd0, 32'd0, 32'd0, 32'd9, 32'd9, 32'd9};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Read monitor: request kind is sampled at the edge, data one step later.
  always @(posedge clk) begin
    logic        rd;
    logic [31:0] e;
    string       nm;
    rd = wb.caravel_wb_cyc_i & wb.caravel_wb_stb_i & ~wb.caravel_wb_we_i;
    #1;
    if (wb.caravel_wb_ack_o && rd) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read_ack", wb.caravel_wb_dat_o, 32'hDEAD_BEEF);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, wb.caravel_wb_dat_o, e);
      end
    end
  end

  task automatic wb_access(input logic [31:0] addr, input logic [31:0] data, input logic we,
                           input logic [3:0] sel, input int bound, output logic acked);
    @(negedge clk);
    wb.caravel_wb_cyc_i = 1'b1;
    wb.caravel_wb_stb_i = 1'b1;
    wb.caravel_wb_we_i  = we;
    wb.caravel_wb_sel_i = sel;
    wb.caravel_wb_dat_i = data;
    wb.caravel_wb_adr_i = addr;
    acked = 1'b0;
    for (int c = 0; c < bound && !acked; c++) begin
      @(posedge clk);
      #1;
      acked = wb.caravel_wb_ack_o;
    end
    wb.caravel_wb_cyc_i = 1'b0;
    wb.caravel_wb_stb_i = 1'b0;
    wb.caravel_wb_we_i  = 1'b0;
    wb.caravel_wb_sel_i = 4'h0;
    wb.caravel_wb_dat_i = 32'd0;
    wb.caravel_wb_adr_i = 32'd0;
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] data, input string name);
    logic a;
    wb_access(BASE + off, data, 1'b1, 4'hF, 8, a);
    if (!a) check({name, "_ack"}, 32'(a), 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] off, input logic [31:0] exp, input string name);
    logic        a;
    logic [31:0] dummy;
    string       dn;
    exp_q.push_back(exp);
    name_q.push_back(name);
    wb_access(BASE + off, 32'd0, 1'b0, 4'hF, 8, a);
    if (!a) begin
      dummy = exp_q.pop_back();
      dn    = name_q.pop_back();
      check({name, "_ack"}, 32'(a), 32'd1);
    end
  endtask

  task automatic load_mats(input logic [7:0] a [9], input logic [7:0] w [9]);
    for (int e = 0; e < 9; e++) begin
      wb_write(OFF_A + 32'(4 * e), 32'(a[e]), "load_a");
      wb_write(OFF_W + 32'(4 * e), 32'(w[e]), "load_w");
    end
  endtask

  task automatic read_c(input logic [31:0] exp [9], input string tag);
    for (int e = 0; e < 9; e++)
      wb_read(OFF_C + 32'(4 * e), exp[e], $sformatf("%s_C%0d", tag, e));
  endtask

  // Call right after the START ack; counts busy samples until done_irq is seen.
  task automatic wait_done(output int cycles, output int busy_cyc);
    cycles   = 0;
    busy_cyc = 0;
    while (!done_irq && cycles < 200) begin
      if (dbg_state inside {3'd1, 3'd2, 3'd3}) busy_cyc++;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done_irq) check("done_timeout", 32'(done_irq), 32'd1);
  endtask

  task automatic reset_now(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_ack"}, 32'(wb.caravel_wb_ack_o), 32'd0);
    check({tag, "_dat"}, wb.caravel_wb_dat_o, 32'd0);
    check({tag, "_irq"}, 32'(done_irq), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, busy;
    logic a;
    wb.caravel_wb_cyc_i = 1'b0;
    wb.caravel_wb_stb_i = 1'b0;
    wb.caravel_wb_we_i  = 1'b0;
    wb.caravel_wb_sel_i = 4'h0;
    wb.caravel_wb_dat_i = 32'd0;
    wb.caravel_wb_adr_i = 32'd0;
    repeat (2) @(negedge clk);
    check("por_irq", 32'(done_irq), 32'd0);
    check("por_ack", 32'(wb.caravel_wb_ack_o), 32'd0);
    rst = 1'b0;
    wb_read(OFF_STAT, 32'h0000_0300, "por_status");
    wb_read(OFF_C, 32'd0, "por_C0");
    wb_read(OFF_C + 32'd32, 32'd0, "por_C8");

    // Identity run, unsigned
    load_mats(a_seq, w_id);
    wb_write(OFF_CTRL, 32'h1, "ident_start");
    wait_done(cyc, busy);
    check("ident_busy_cycles", 32'(busy), 32'd9);
    check("ident_done_latency", 32'(cyc), 32'd9);
    check("ident_irq", 32'(done_irq), 32'd1);
    wb_read(OFF_STAT, 32'h0000_0302, "ident_status");
    read_c(c_id, "ident");
    wb_read(OFF_A + 32'd16, 32'd5, "ident_A4");

    // Asynchronous reset mid-cycle clears everything
    @(posedge clk);
    #3;
    reset_now("mid_rst");
    wb_read(OFF_STAT, 32'h0000_0300, "mid_rst_status");
    read_c(c_zero, "mid_rst");
    wb_read(OFF_W + 32'd16, 32'd0, "mid_rst_W4");

    // Signedness
    load_mats(a_ff, w_two);
    wb_write(OFF_CTRL, 32'h5, "sgn_start");
    wait_done(cyc, busy);
    read_c(c_sneg, "sgn");
    wb_read(OFF_A, 32'h0000_00FF, "sgn_A0_zext");
    wb_write(OFF_CTRL, 32'h1, "uns_start");
    wait_done(cyc, busy);
    read_c(c_upos, "uns");

    // Protection during busy
    load_mats(a_seq, w_mix);
    wb_write(OFF_CTRL, 32'h1, "prot_start");
    wb_write(OFF_W, 32'h55, "prot_w0_busy");
    wb_write(OFF_CTRL, 32'h1, "prot_start_busy");
    wb_read(OFF_STAT, 32'h0000_0305, "prot_status_busy");
    wb_read(OFF_C, 32'h0000_05FA, "prot_C0_prev");
    wait_done(cyc, busy);
    read_c(c_mix, "prot");
    wb_read(OFF_W, 32'd1, "prot_W0_kept");
    wb_read(OFF_STAT, 32'h0000_0306, "prot_status_err");
    wb_write(OFF_CTRL, 32'h2, "prot_clear");
    wb_read(OFF_STAT, 32'h0000_0300, "prot_status_clr");

    // Abort at RUN step 3
    wb_write(OFF_CTRL, 32'h1, "abort_start");
    repeat (4) @(posedge clk);
    #3;
    check("abort_in_run", 32'(dbg_state), 32'd2);
    reset_now("abort");
    wb_read(OFF_STAT, 32'h0000_0300, "abort_status");
    read_c(c_zero, "abort");
    load_mats(a_sgn, w_one);
    wb_write(OFF_CTRL, 32'h5, "fresh_start");
    wait_done(cyc, busy);
    check("fresh_busy_cycles", 32'(busy), 32'd9);
    read_c(c_sgn, "fresh");
    wb_read(OFF_STAT, 32'h0000_0302, "fresh_status");

    // Decode corners
    wb_access(BASE + 32'h400, 32'd0, 1'b0, 4'hF, 4, a);
    check("dec_outside_noack", 32'(a), 32'd0);
    wb_read(32'h008, 32'd0, "dec_hole_read");
    wb_read(OFF_CTRL, 32'd0, "dec_ctrl_read");
    wb_access(BASE + OFF_W, 32'h77, 1'b1, 4'b1110, 8, a);
    check("dec_sel_ack", 32'(a), 32'd1);
    wb_read(OFF_W, 32'd1, "dec_sel_W0_kept");

    repeat (3) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
